// File: rtl/fmc_adc_pkg.sv
// fmc_adc_pkg: checker state encoding shared by the ADC data monitor blocks
package fmc_adc_pkg;
  typedef logic [1:0] chk_state_t;
  localparam chk_state_t c_CHK_IDLE = 2'd0;
  localparam chk_state_t c_CHK_SEEK = 2'd1;
  localparam chk_state_t c_CHK_LOCK = 2'd2;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with priority clear
//   clk_i/rst_n_i : clock, async active-low reset
//   inc_i         : count up by one, holds at all-ones
//   clr_i         : synchronous clear, wins over inc_i
//   cnt_o         : current count
module sat_counter #(
  parameter int g_width = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               inc_i,
  input  logic               clr_i,
  output logic [g_width-1:0] cnt_o
);
  logic [g_width-1:0] cnt_d, cnt_q;
  always_comb cnt_d = clr_i ? '0 : (inc_i && !(&cnt_q)) ? cnt_q + g_width'(1) : cnt_q;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/ltc_data_monitor.sv
// ltc_data_monitor: LTC2208 sample formatter, overflow statistics and test-pattern checker
//   adc_clk_i/rst_n_i   : ADC clock, async active-low reset
//   adc_data_i/valid_i  : capture word {ov, data}, qualifier
//   fmt_twos_i          : 1 two's complement input, 0 offset binary
//   chk_en_i/mode_i     : checker enable, 0 ramp / 1 fixed pattern
//   chk_pattern_i       : expected word in fixed mode
//   cnt_clr_i           : clears ov counter, ov sticky and checker error counter
//   adc_data_o/ov_o/valid_o : registered two's complement sample
//   ov_sticky_o/ov_cnt_o    : overflow statistics
//   chk_state_o/lock_o/err_cnt_o : checker status
module ltc_data_monitor
  import fmc_adc_pkg::*;
#(
  parameter int g_num_bits      = 16,
  parameter int g_ov_cnt_width  = 16,
  parameter int g_err_cnt_width = 16,
  parameter int g_lock_count    = 8
) (
  input  logic                       adc_clk_i,
  input  logic                       rst_n_i,
  input  logic [g_num_bits:0]        adc_data_i,
  input  logic                       adc_valid_i,
  input  logic                       fmt_twos_i,
  input  logic                       chk_en_i,
  input  logic                       chk_mode_i,
  input  logic [g_num_bits-1:0]      chk_pattern_i,
  input  logic                       cnt_clr_i,
  output logic [g_num_bits-1:0]      adc_data_o,
  output logic                       adc_ov_o,
  output logic                       adc_valid_o,
  output logic                       ov_sticky_o,
  output logic [g_ov_cnt_width-1:0]  ov_cnt_o,
  output logic [1:0]                 chk_state_o,
  output logic                       chk_lock_o,
  output logic [g_err_cnt_width-1:0] chk_err_cnt_o
);
  localparam int c_mw = $clog2(g_lock_count + 1);
  logic [g_num_bits-1:0] raw, data_d, data_q, exp_d, exp_q;
  logic ov_d, ov_q, valid_d, valid_q, sticky_d, sticky_q, first_d, first_q, match_ok, ov_hit, err_inc;
  logic [c_mw-1:0] match_d, match_q;
  chk_state_t state_d, state_q;
  assign raw = adc_data_i[g_num_bits-1:0];
  assign ov_hit = adc_valid_i & adc_data_i[g_num_bits];
  // The first ramp sample after entering SEEK only seeds exp, so it never counts as a match.
  assign match_ok = chk_mode_i ? (raw == chk_pattern_i) : (raw == exp_q) & ~first_q;
  assign err_inc = (state_q == c_CHK_LOCK) & adc_valid_i & ~match_ok;
  always_comb begin
    data_d = adc_valid_i ? (fmt_twos_i ? raw : {~raw[g_num_bits-1], raw[g_num_bits-2:0]}) : data_q;
    ov_d = adc_valid_i ? adc_data_i[g_num_bits] : ov_q;
    valid_d = adc_valid_i;
    sticky_d = cnt_clr_i ? 1'b0 : sticky_q | ov_hit;
  end
  always_comb begin
    state_d = state_q;
    exp_d = exp_q;
    match_d = match_q;
    first_d = first_q;
    if (state_q == c_CHK_IDLE) begin
      match_d = '0;
      first_d = 1'b1;
      if (chk_en_i) state_d = c_CHK_SEEK;
    end else if (adc_valid_i) begin
      exp_d = chk_mode_i ? chk_pattern_i : raw + g_num_bits'(1);
      first_d = 1'b0;
      if (state_q == c_CHK_SEEK) begin
        match_d = match_ok ? match_q + c_mw'(1) : '0;
        if (match_d == c_mw'(g_lock_count)) state_d = c_CHK_LOCK;
      end
    end
    if (!chk_en_i) state_d = c_CHK_IDLE;
  end
  always_comb begin
    chk_state_o = state_q;
    chk_lock_o = state_q == c_CHK_LOCK;
  end
  always_ff @(posedge adc_clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      data_q <= '0;
      ov_q <= 1'b0;
      valid_q <= 1'b0;
      sticky_q <= 1'b0;
      state_q <= c_CHK_IDLE;
      exp_q <= '0;
      match_q <= '0;
      first_q <= 1'b0;
    end else begin
      data_q <= data_d;
      ov_q <= ov_d;
      valid_q <= valid_d;
      sticky_q <= sticky_d;
      state_q <= state_d;
      exp_q <= exp_d;
      match_q <= match_d;
      first_q <= first_d;
    end
  sat_counter #(.g_width(g_ov_cnt_width)) u_ov_cnt (
    .clk_i(adc_clk_i), .rst_n_i(rst_n_i), .inc_i(ov_hit), .clr_i(cnt_clr_i), .cnt_o(ov_cnt_o)
  );
  sat_counter #(.g_width(g_err_cnt_width)) u_err_cnt (
    .clk_i(adc_clk_i), .rst_n_i(rst_n_i), .inc_i(err_inc), .clr_i(cnt_clr_i), .cnt_o(chk_err_cnt_o)
  );
  assign adc_data_o = data_q;
  assign adc_ov_o = ov_q;
  assign adc_valid_o = valid_q;
  assign ov_sticky_o = sticky_q;
endmodule
